// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmitter.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} spi_tx_state_t;

  localparam int unsigned FRAME_LEN8  = 8;
  localparam int unsigned FRAME_LEN16 = 16;
  localparam int unsigned BIT_CNT_W   = 5;
  localparam int unsigned SHIFT_W     = 16;

  // Number of sample edges in a frame for the latched length select.
  function automatic logic [BIT_CNT_W-1:0] frame_bits(input logic len8);
    return len8 ? BIT_CNT_W'(FRAME_LEN8) : BIT_CNT_W'(FRAME_LEN16);
  endfunction

endpackage

// File: rtl/spi_tx_baud.sv
// Half-period tick generator: tick_c is high in the last cycle of every HALF-cycle window.
module spi_tx_baud #(
  parameter int unsigned HALF = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_tx.sv
// SPI master transmitter: one 8/16-bit MSB-first frame per accepted wrt, SCLK idles high,
// all pin outputs registered.
module spi_tx
  import spi_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] tx_data,
  input  logic        len8_16,
  input  logic        edg,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HALF = SCLK_DIV / 2;

  spi_tx_state_t          state_q, state_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   len8_q, len8_d;
  logic                   edg_q, edg_d;
  logic                   ss_n_q, ss_n_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tick_c, baud_clr_c, fall_c, rise_c, adv_c, last_c;

  spi_tx_baud #(.HALF(HALF)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (baud_clr_c),
    .tick_c (tick_c)
  );

  assign last_c = (bit_cnt_q == frame_bits(len8_q));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    len8_d     = len8_q;
    edg_d      = edg_q;
    ss_n_d     = ss_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    baud_clr_c = 1'b0;
    fall_c     = 1'b0;
    rise_c     = 1'b0;
    adv_c      = 1'b0;

    case (state_q)
      IDLE: begin
        baud_clr_c = 1'b1;
        if (wrt) begin
          len8_d    = len8_16;
          edg_d     = edg;
          // MOSI carries the first bit; the shift register holds the rest, MSB-aligned
          mosi_d    = len8_16 ? tx_data[7] : tx_data[15];
          shift_d   = len8_16 ? {tx_data[6:0], 9'h000} : {tx_data[14:0], 1'b0};
          bit_cnt_d = '0;
          ss_n_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b1;
          state_d   = FRONT;
        end
      end
      FRONT: begin
        if (tick_c) begin
          fall_c  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (!sclk_q)     rise_c  = 1'b1;
          else if (last_c) state_d = BACK;
          else             fall_c  = 1'b1;
        end
      end
      BACK: begin
        if (tick_c) begin
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sample edges are counted; MOSI moves on the opposite edge only after a sample edge
    if (fall_c) begin
      sclk_d = 1'b0;
      if (!edg_q)                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      else if (bit_cnt_q != '0)    adv_c     = 1'b1;
    end
    if (rise_c) begin
      sclk_d = 1'b1;
      if (edg_q)                   bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      else if (!last_c)            adv_c     = 1'b1;
    end
    if (adv_c) begin
      mosi_d  = shift_q[SHIFT_W-1];
      shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      len8_q    <= 1'b0;
      edg_q     <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      len8_q    <= len8_d;
      edg_q     <= edg_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SS_n = ss_n_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: a pin-level receiver model checks data, framing, timing and MOSI stability
// on one instance at SCLK_DIV=32 (index 0) and one at SCLK_DIV=4 (index 1).
module tb_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  wrt, len8, edg;
  logic [15:0] txd0, txd1;
  wire  [1:0]  ss_n, sclk, mosi, busy, done;

  int tests = 0;
  int fails = 0;

  spi_tx #(.SCLK_DIV(32)) u_div32 (
    .clk(clk), .rst(rst), .wrt(wrt[0]), .tx_data(txd0), .len8_16(len8[0]), .edg(edg[0]),
    .SS_n(ss_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .busy(busy[0]), .done(done[0])
  );

  spi_tx #(.SCLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .wrt(wrt[1]), .tx_data(txd1), .len8_16(len8[1]), .edg(edg[1]),
    .SS_n(ss_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int idx, input logic [15:0] d, input logic l8, input logic e);
    if (idx == 0) txd0 = d; else txd1 = d;
    len8[idx] = l8;
    edg[idx]  = e;
  endtask

  task automatic drive_req(input int idx, input logic [15:0] d, input logic l8, input logic e);
    @(negedge clk);
    set_fields(idx, d, l8, e);
    wrt[idx] = 1'b1;
  endtask

  // Observes one frame whose request is sampled at the next posedge; ends on the done cycle.
  task automatic run_frame(input int idx, input logic [15:0] d, input logic l8, input logic e,
                           input bit keep_wrt, input bit poke, input string tag);
    int h, div, n, cyc, ss_low, busy_cnt, edges, viol, done_cyc, last_chg, last_smp;
    logic [15:0] rx, exp_rx;
    logic p_sclk, p_mosi, p_ss, first_ss;
    bit got_done;
    h = (idx == 0) ? 16 : 2;
    div = 2 * h;
    n = l8 ? 8 : 16;
    exp_rx = l8 ? {8'h00, d[7:0]} : d;
    cyc = 0; ss_low = 0; busy_cnt = 0; edges = 0; viol = 0; done_cyc = 0;
    last_chg = 1; last_smp = -1000;
    rx = '0; p_sclk = 1'b1; p_mosi = 1'b0; p_ss = 1'b1; first_ss = 1'b1; got_done = 0;
    while (!got_done && cyc < 40 * div) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first_ss = ss_n[idx];
      if (cyc == 1 && !keep_wrt) wrt[idx] = 1'b0;
      if (poke && cyc == 3 * h) begin
        set_fields(idx, 16'hFFFF, ~l8, ~e);
        wrt[idx] = 1'b1;
      end
      if (poke && cyc == 3 * h + 1) wrt[idx] = 1'b0;
      if (!ss_n[idx]) ss_low++;
      if (busy[idx])  busy_cnt++;
      if (!ss_n[idx] && !p_ss) begin
        if (sclk[idx] != p_sclk && sclk[idx] == e) begin
          edges++;
          rx = {rx[14:0], mosi[idx]};
          if (mosi[idx] != p_mosi) viol++;
          if (cyc - last_chg < h) viol++;
          last_smp = cyc;
        end else if (mosi[idx] != p_mosi) begin
          if (cyc - last_smp < h) viol++;
          last_chg = cyc;
        end
      end
      if (done[idx]) begin
        got_done = 1;
        done_cyc = cyc;
      end
      p_sclk = sclk[idx];
      p_mosi = mosi[idx];
      p_ss   = ss_n[idx];
    end
    check($sformatf("%s rx_data", tag), 32'(rx), 32'(exp_rx));
    check($sformatf("%s sample_edges", tag), 32'(edges), 32'(n));
    check($sformatf("%s ss_low_cycles", tag), 32'(ss_low), 32'((n + 1) * div));
    check($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'((n + 1) * div));
    check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(1 + (n + 1) * div));
    check($sformatf("%s mosi_stability", tag), 32'(viol), 32'd0);
    check($sformatf("%s first_cycle_ss_n", tag), 32'(first_ss), 32'd0);
    check($sformatf("%s done_pins", tag),
          32'({ss_n[idx], sclk[idx], mosi[idx], busy[idx]}), 32'(4'b1100));
  endtask

  task automatic count_done(input int idx, input int cycles, input string tag);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done[idx]) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int idx;
    logic [15:0] d;
    logic l8, e;

    rst = 1'b1; wrt = '0; len8 = '0; edg = '0; txd0 = '0; txd1 = '0;
    repeat (3) @(negedge clk);
    check("reset pins div32", 32'({ss_n[0], sclk[0], mosi[0], busy[0], done[0]}), 32'(5'b11000));
    check("reset pins div4",  32'({ss_n[1], sclk[1], mosi[1], busy[1], done[1]}), 32'(5'b11000));
    rst = 1'b0;
    count_done(0, 4, "idle no done");

    drive_req(0, 16'h00A5, 1'b1, 1'b1);
    run_frame(0, 16'h00A5, 1'b1, 1'b1, 0, 0, "len8 rise");

    drive_req(0, 16'hC3E1, 1'b0, 1'b0);
    run_frame(0, 16'hC3E1, 1'b0, 1'b0, 0, 0, "len16 fall");

    drive_req(0, 16'h5A3C, 1'b0, 1'b1);
    run_frame(0, 16'h5A3C, 1'b0, 1'b1, 0, 1, "wrt while busy");
    count_done(0, 64, "single done pulse");

    drive_req(0, 16'h9617, 1'b0, 1'b1);
    run_frame(0, 16'h9617, 1'b0, 1'b1, 1, 0, "b2b first");
    set_fields(0, 16'h3C4B, 1'b1, 1'b0);
    run_frame(0, 16'h3C4B, 1'b1, 1'b0, 0, 0, "b2b second");

    drive_req(1, 16'hB26D, 1'b0, 1'b1);
    run_frame(1, 16'hB26D, 1'b0, 1'b1, 0, 0, "div4 len16 rise");
    drive_req(1, 16'h1E87, 1'b0, 1'b0);
    run_frame(1, 16'h1E87, 1'b0, 1'b0, 0, 0, "div4 len16 fall");
    drive_req(1, 16'h00C9, 1'b1, 1'b0);
    run_frame(1, 16'h00C9, 1'b1, 1'b0, 0, 0, "div4 len8 fall");

    for (int i = 0; i < 8; i++) begin
      idx = int'($urandom_range(0, 1));
      d   = 16'($urandom);
      l8  = 1'($urandom);
      e   = 1'($urandom);
      drive_req(idx, d, l8, e);
      run_frame(idx, d, l8, e, 0, 0, $sformatf("random %0d", i));
    end

    drive_req(0, 16'hA55A, 1'b0, 1'b1);
    @(negedge clk);
    wrt[0] = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midframe reset %0d", i),
            32'({ss_n[0], sclk[0], mosi[0], busy[0], done[0]}), 32'(5'b11000));
    end
    rst = 1'b0;
    count_done(0, 600, "abandoned frame no done");
    check("post reset pins", 32'({ss_n[0], sclk[0], mosi[0], busy[0]}), 32'(4'b1100));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
